// File: rtl/vga_timing_pkg.sv
// Shared VGA types: 12-bit RGB colour, per-axis timing record, standard 640x480 mode.
// Also holds the colour-bar lookup used by the optional built-in test pattern.
package vga_timing_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    typedef struct packed {
        logic [11:0] visible;
        logic [11:0] front;
        logic [11:0] sync;
        logic [11:0] back;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480 = '{
        h: '{visible: 12'd640, front: 12'd16, sync: 12'd96, back: 12'd48},
        v: '{visible: 12'd480, front: 12'd10, sync: 12'd2,  back: 12'd33}
    };

    // Bars run left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic color_t bar_color(input logic [2:0] idx);
        color_t c;
        case (idx)
            3'd0:    c = color_t'(12'hFFF);
            3'd1:    c = color_t'(12'hFF0);
            3'd2:    c = color_t'(12'h0FF);
            3'd3:    c = color_t'(12'h0F0);
            3'd4:    c = color_t'(12'hF0F);
            3'd5:    c = color_t'(12'hF00);
            3'd6:    c = color_t'(12'h00F);
            default: c = color_t'(12'h000);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_mod_counter.sv
// Modulo-N counter advancing on en_i; wrap_o flags the enabled step that returns to zero.
module mod_counter #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == W'(N - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: pixel tick every 2nd clk, one-clk pixel requests, pins one tick after request.
// Define VGA_TEST_PATTERN_EN to let test_en substitute eight vertical colour bars for pix_color.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = int'(VGA_640x480.h.visible),
    parameter int H_FRONT   = int'(VGA_640x480.h.front),
    parameter int H_SYNC    = int'(VGA_640x480.h.sync),
    parameter int H_BACK    = int'(VGA_640x480.h.back),
    parameter int V_VISIBLE = int'(VGA_640x480.v.visible),
    parameter int V_FRONT   = int'(VGA_640x480.v.front),
    parameter int V_SYNC    = int'(VGA_640x480.v.sync),
    parameter int V_BACK    = int'(VGA_640x480.v.back)
) (
    input  logic       clk,
    input  logic       rst_,
    output logic       pix_req,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    input  color_t     pix_color,
    output logic       frame_start,
    output color_t     vga_color,
    output logic       vga_hs,
    output logic       vga_vs,
    input  logic       test_en
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_VISIBLE > 1024 || V_VISIBLE > 1024) begin : g_bad_geometry
        $error("vga_timing: visible area exceeds 10-bit pixel coordinates");
    end

    logic          phase_q, phase_d;
    logic          tick;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          unused_v_wrap;
    logic          in_vis, in_hsync, in_vsync;

    logic          pix_req_q, pix_req_d;
    logic          frame_start_q, frame_start_d;
    logic [9:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          vis_stage_q, vis_stage_d;
    logic          hs_stage_q, hs_stage_d, vs_stage_q, vs_stage_d;
    color_t        col_q, col_d;
    color_t        src_color;
    color_t        vga_color_q, vga_color_d;
    logic          vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;

    assign tick = phase_q;

    mod_counter #(.N(H_TOTAL)) u_h_cnt (
        .clk    (clk),
        .rst_   (rst_),
        .en_i   (tick),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap)
    );

    mod_counter #(.N(V_TOTAL)) u_v_cnt (
        .clk    (clk),
        .rst_   (rst_),
        .en_i   (h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (unused_v_wrap)
    );

    assign in_vis   = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);
    assign in_hsync = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
    assign in_vsync = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_VISIBLE >= 8) ? H_VISIBLE / 8 : 1;
    logic [9:0] bar_idx;
    assign bar_idx   = pix_x_q / 10'(BAR_W);
    assign src_color = test_en ? bar_color((bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0]) : pix_color;
`else
    logic unused_test_en;
    assign unused_test_en = test_en;
    assign src_color      = pix_color;
`endif

    // Requests launch on tick edges; colour is captured on the following non-tick edge,
    // and the pins update on the next tick, so sync is staged one tick to stay aligned.
    always_comb begin
        phase_d       = ~phase_q;
        pix_req_d     = 1'b0;
        frame_start_d = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        vis_stage_d   = vis_stage_q;
        hs_stage_d    = hs_stage_q;
        vs_stage_d    = vs_stage_q;
        col_d         = col_q;
        vga_color_d   = vga_color_q;
        vga_hs_d      = vga_hs_q;
        vga_vs_d      = vga_vs_q;

        if (pix_req_q) begin
            col_d = src_color;
        end

        if (tick) begin
            pix_req_d     = in_vis;
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            if (in_vis) begin
                pix_x_d = 10'(h_cnt);
                pix_y_d = 10'(v_cnt);
            end
            vis_stage_d = in_vis;
            hs_stage_d  = ~in_hsync;
            vs_stage_d  = ~in_vsync;
            vga_color_d = vis_stage_q ? col_q : '0;
            vga_hs_d    = hs_stage_q;
            vga_vs_d    = vs_stage_q;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q       <= 1'b0;
            pix_req_q     <= 1'b0;
            frame_start_q <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            vis_stage_q   <= 1'b0;
            hs_stage_q    <= 1'b1;
            vs_stage_q    <= 1'b1;
            col_q         <= '0;
            vga_color_q   <= '0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
        end else begin
            phase_q       <= phase_d;
            pix_req_q     <= pix_req_d;
            frame_start_q <= frame_start_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            vis_stage_q   <= vis_stage_d;
            hs_stage_q    <= hs_stage_d;
            vs_stage_q    <= vs_stage_d;
            col_q         <= col_d;
            vga_color_q   <= vga_color_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
        end
    end

    assign pix_req     = pix_req_q;
    assign frame_start = frame_start_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign vga_color   = vga_color_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a scaled-down raster (64x8 visible, 80x14 total) so whole
// frames stay short; every expected value below is derived from that geometry by hand.
module tb_vga_timing;
    import vga_timing_pkg::*;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLK = 2 * HT * VT;
    localparam int LIMIT = 3 * FRAME_CLK;

    logic       clk = 1'b0;
    logic       rst_;
    logic       pix_req, frame_start, vga_hs, vga_vs, test_en;
    logic [9:0] pix_x, pix_y;
    color_t     pix_color, vga_color;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk         (clk),
        .rst_        (rst_),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .frame_start (frame_start),
        .vga_color   (vga_color),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .test_en     (test_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int x, input int y, input string tag);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(pix_req === 1'b1 && int'(pix_x) == x && int'(pix_y) == y) && n < LIMIT);
        chk(tag, 32'(n < LIMIT), 1);
    endtask

    initial begin
        int   cyc, nreq, nhs, nvs, hs_run, vs_low, bad_hs, n;
        logic hs_prev, vs_prev;

        rst_      = 1'b0;
        pix_color = '0;
        test_en   = 1'b0;
        step(4);
        chk("rst_pix_req",     32'(pix_req),     0);
        chk("rst_pix_x",       32'(pix_x),       0);
        chk("rst_pix_y",       32'(pix_y),       0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_vga_hs",      32'(vga_hs),      1);
        chk("rst_vga_vs",      32'(vga_vs),      1);
        chk("rst_vga_color",   32'(vga_color),   0);

        // First tick lands on the second edge after release, at pixel (0,0).
        rst_ = 1'b1;
        step(1);
        chk("clk1_no_req", 32'(pix_req), 0);
        step(1);
        chk("clk2_req",         32'(pix_req),     1);
        chk("clk2_x",           32'(pix_x),       0);
        chk("clk2_y",           32'(pix_y),       0);
        chk("clk2_frame_start", 32'(frame_start), 1);
        step(1);
        chk("clk3_req_low",    32'(pix_req),     0);
        chk("clk3_fs_low",     32'(frame_start), 0);

        // Full frame: from this frame_start (clk 2) to the next one.
        cyc = 1; nreq = 1; nhs = 0; nvs = 0; hs_run = 0; vs_low = 0; bad_hs = 0;
        hs_prev = vga_hs; vs_prev = vga_vs;
        do begin
            step(1);
            cyc++;
            if (pix_req === 1'b1 && frame_start !== 1'b1) nreq++;
            if (vga_hs === 1'b0) begin
                if (hs_prev) nhs++;
                hs_run++;
            end else if (!hs_prev) begin
                if (hs_run != 2 * HS) bad_hs++;
                hs_run = 0;
            end
            if (vga_vs === 1'b0) begin
                if (vs_prev) nvs++;
                vs_low++;
            end
            hs_prev = vga_hs;
            vs_prev = vga_vs;
        end while (frame_start !== 1'b1 && cyc < LIMIT);
        chk("frame_period",    32'(cyc),    FRAME_CLK);
        chk("frame_pix_reqs",  32'(nreq),   HV * VV);
        chk("frame_hs_pulses", 32'(nhs),    VT);
        chk("hs_width_bad",    32'(bad_hs), 0);
        chk("frame_vs_pulses", 32'(nvs),    1);
        chk("vs_width_clk",    32'(vs_low), 2 * HT * VS);

        // Last visible pixel carries a colour, then the line goes into blanking.
        wait_req(HV - 1, VV - 1, "reach_last_px");
        pix_color = color_t'(12'hF0A);
        step(1);
        pix_color = '0;
        chk("last_px_req_low", 32'(pix_req),   0);
        chk("last_px_x_hold",  32'(pix_x),     HV - 1);
        chk("last_px_y_hold",  32'(pix_y),     VV - 1);
        chk("prev_px_color",   32'(vga_color), 0);
        step(1);
        chk("last_px_color",      32'(vga_color), 'hF0A);
        step(1);
        chk("last_px_color_hold", 32'(vga_color), 'hF0A);
        step(1);
        chk("blank_color",        32'(vga_color), 0);

        // Reset while a colour is on the pins: everything clears at once, then restarts.
        wait_req(HV / 2, VV / 2, "reach_mid_px");
        pix_color = color_t'(12'h5A5);
        step(1);
        pix_color = '0;
        step(1);
        chk("mid_px_color", 32'(vga_color), 'h5A5);
        rst_ = 1'b0;
        #1;
        chk("midrst_color",   32'(vga_color), 0);
        chk("midrst_hs",      32'(vga_hs),    1);
        chk("midrst_vs",      32'(vga_vs),    1);
        chk("midrst_pix_req", 32'(pix_req),   0);
        chk("midrst_pix_x",   32'(pix_x),     0);
        step(3);
        rst_ = 1'b1;
        step(1);
        chk("restart1_no_req", 32'(pix_req), 0);
        step(1);
        chk("restart1_req", 32'(pix_req),     1);
        chk("restart1_x",   32'(pix_x),       0);
        chk("restart1_y",   32'(pix_y),       0);
        chk("restart1_fs",  32'(frame_start), 1);

        // Reset while both sync pulses are active: no partial pulse survives.
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(vga_hs === 1'b0 && vga_vs === 1'b0) && n < LIMIT);
        chk("reach_sync", 32'(n < LIMIT), 1);
        rst_ = 1'b0;
        #1;
        chk("syncrst_hs", 32'(vga_hs), 1);
        chk("syncrst_vs", 32'(vga_vs), 1);
        step(2);
        rst_ = 1'b1;
        step(2);
        chk("restart2_req", 32'(pix_req),     1);
        chk("restart2_fs",  32'(frame_start), 1);

        pix_color = color_t'(12'hABC);
        test_en   = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
        wait_req(0, 1, "reach_bar0");
        step(2);
        chk("bar0_white", 32'(vga_color), 'hFFF);
        wait_req(HV / 8, 1, "reach_bar1");
        step(2);
        chk("bar1_yellow", 32'(vga_color), 'hFF0);
        wait_req(7 * HV / 8, 1, "reach_bar7");
        step(2);
        chk("bar7_black", 32'(vga_color), 'h000);
`else
        wait_req(0, 1, "reach_x0");
        step(2);
        chk("test_en_ignored_x0", 32'(vga_color), 'hABC);
        wait_req(7 * HV / 8, 1, "reach_x56");
        step(2);
        chk("test_en_ignored_x56", 32'(vga_color), 'hABC);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
